// File: rtl/sim_end_monitor_pkg.sv
// Shared definitions for the simulation end monitor: default widths,
// register indices of the test-end signature and the monitor state encoding.
package sim_end_monitor_pkg;

  localparam int MON_CPU_WIDTH = 32;

  localparam logic [4:0] MON_END_REG  = 5'd26;
  localparam logic [4:0] MON_PASS_REG = 5'd27;
  localparam logic [4:0] MON_TNUM_REG = 5'd3;

  typedef enum logic [1:0] {
    MON_RUN    = 2'd0,
    MON_SETTLE = 2'd1,
    MON_DONE   = 2'd2
  } mon_state_e;

  // x0 is hard-wired to zero in the core, so writes to it never count.
  function automatic logic reg_write_hit(input logic       we,
                                         input logic [4:0] waddr,
                                         input logic [4:0] idx);
    return we && (waddr != 5'd0) && (waddr == idx);
  endfunction

endpackage

// File: rtl/sim_end_monitor_sat_counter.sv
// Free-running up counter with synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sim_end_monitor.sv
// Pass/fail/timeout monitor snooping the core's regfile write port.
// Define MONITOR_TRACE_EN to get a simulation-only verdict trace.
module sim_end_monitor
  import sim_end_monitor_pkg::*;
#(
  parameter int CPU_WIDTH      = MON_CPU_WIDTH,
  parameter int END_REG        = int'(MON_END_REG),
  parameter int PASS_REG       = int'(MON_PASS_REG),
  parameter int TNUM_REG       = int'(MON_TNUM_REG),
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_we,
  input  logic [4:0]           wb_waddr,
  input  logic [CPU_WIDTH-1:0] wb_wdata,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [CPU_WIDTH-1:0] fail_testnum,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [4:0]           END_IDX     = 5'(END_REG);
  localparam logic [4:0]           PASS_IDX    = 5'(PASS_REG);
  localparam logic [4:0]           TNUM_IDX    = 5'(TNUM_REG);
  localparam logic [7:0]           SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CPU_WIDTH-1:0] ONE         = CPU_WIDTH'(1);

  mon_state_e           state_q;
  logic [7:0]           settle_q;
  logic [CPU_WIDTH-1:0] pass_sh_q, pass_sh_d;
  logic [CPU_WIDTH-1:0] tnum_sh_q, tnum_sh_d;
  logic                 done_q, pass_q, fail_q, timeout_q;
  logic [CPU_WIDTH-1:0] fail_tnum_q;

  logic end_evt, pass_wr, tnum_wr, tmo_hit, cnt_en;

  assign pass_wr = reg_write_hit(wb_we, wb_waddr, PASS_IDX);
  assign tnum_wr = reg_write_hit(wb_we, wb_waddr, TNUM_IDX);
  assign end_evt = reg_write_hit(wb_we, wb_waddr, END_IDX) && (wb_wdata == ONE);
  assign tmo_hit = (cycle_count == TMO_LAST);

  // The timeout edge itself does not count, so the counter freezes at TIMEOUT-1.
  assign cnt_en = ((state_q == MON_RUN) && !(tmo_hit && !end_evt)) ||
                  (state_q == MON_SETTLE);

  always_comb begin
    pass_sh_d = pass_sh_q;
    tnum_sh_d = tnum_sh_q;
    if (state_q != MON_DONE) begin
      if (pass_wr) pass_sh_d = wb_wdata;
      if (tnum_wr) tnum_sh_d = wb_wdata;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cycle_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (cnt_en),
    .cnt_o (cycle_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MON_RUN;
      settle_q    <= '0;
      pass_sh_q   <= '0;
      tnum_sh_q   <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_tnum_q <= '0;
    end else begin
      pass_sh_q <= pass_sh_d;
      tnum_sh_q <= tnum_sh_d;
      case (state_q)
        MON_RUN: begin
          // An end event in the expiry cycle beats the timeout.
          if (end_evt) begin
            state_q  <= MON_SETTLE;
            settle_q <= SETTLE_INIT;
          end else if (tmo_hit) begin
            state_q   <= MON_DONE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        MON_SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q <= MON_DONE;
            done_q  <= 1'b1;
            if (pass_sh_q == ONE) begin
              pass_q <= 1'b1;
            end else begin
              fail_q      <= 1'b1;
              fail_tnum_q <= tnum_sh_q;
            end
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        MON_DONE: begin
          state_q <= MON_DONE;
        end
        default: begin
          state_q <= MON_RUN;
        end
      endcase
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign fail_testnum = fail_tnum_q;

`ifdef MONITOR_TRACE_EN
  logic [CPU_WIDTH-1:0] tnum_log [$];

  always @(posedge clk) begin
    if (rst) begin
      tnum_log.delete();
    end else if (state_q != MON_DONE) begin
      if ((state_q == MON_RUN) && !end_evt && tmo_hit) begin
        $display("TIMEOUT cycle_count=%0d", cycle_count);
      end else if ((state_q == MON_SETTLE) && (settle_q == 8'd0)) begin
        if (pass_sh_q == ONE) begin
          $display("PASS cycle_count=%0d", cycle_count + 1'b1);
        end else begin
          $display("FAIL testnum=%0d cycle_count=%0d", tnum_sh_q, cycle_count + 1'b1);
          foreach (tnum_log[i]) $display("  testnum write %0d: %0d", i, tnum_log[i]);
        end
      end
      if (tnum_wr) tnum_log.push_back(wb_wdata);
    end
  end
`else
  // Synthesizable build: no trace logic.
`endif

endmodule

// File: tb/tb_sim_end_monitor.sv
// Bench for sim_end_monitor: three instances with settle windows 1, 2 and 0
// share one stimulus and are compared every cycle against a write-log model.
module tb_sim_end_monitor;

  localparam int TMO  = 100;
  localparam int LOGN = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;

  logic [2:0]  done_v, pass_v, fail_v, to_v;
  logic [31:0] tnum_v [3];
  logic [31:0] cnt_v  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_end_monitor #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .timeout(to_v[0]),
    .fail_testnum(tnum_v[0]), .cycle_count(cnt_v[0]));

  sim_end_monitor #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .timeout(to_v[1]),
    .fail_testnum(tnum_v[1]), .cycle_count(cnt_v[1]));

  sim_end_monitor #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut_c (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .timeout(to_v[2]),
    .fail_testnum(tnum_v[2]), .cycle_count(cnt_v[2]));

  // Write log since the last reset edge; index = edges after reset.
  logic        lg_we   [LOGN];
  logic [4:0]  lg_addr [LOGN];
  logic [31:0] lg_data [LOGN];
  int          ecnt = 0;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        to;
    logic [31:0] tnum;
    logic [31:0] cnt;
  } exp_t;

  // Verdict derived from the whole write log: find the first end event
  // before expiry, place the verdict S+1 edges later, and read the last
  // PASS/TNUM writes that land before the verdict edge.
  function automatic exp_t model(input int s, input int k);
    exp_t        r;
    int          end_at;
    int          v;
    logic [31:0] p;
    logic [31:0] t;
    r = '0;
    end_at = 0;
    p = '0;
    t = '0;
    for (int e = 1; e <= k && e <= TMO; e++)
      if (end_at == 0 && lg_we[e] && lg_addr[e] == 5'd26 && lg_data[e] == 32'd1) end_at = e;
    if (end_at != 0) begin
      v = end_at + s + 1;
      if (k >= v) begin
        for (int e = 1; e < v; e++) begin
          if (lg_we[e] && lg_addr[e] == 5'd27) p = lg_data[e];
          if (lg_we[e] && lg_addr[e] == 5'd3)  t = lg_data[e];
        end
        r.done = 1'b1;
        if (p == 32'd1) r.pass = 1'b1;
        else begin
          r.fail = 1'b1;
          r.tnum = t;
        end
        r.cnt = 32'(v);
      end else begin
        r.cnt = 32'(k);
      end
    end else if (k >= TMO) begin
      r.done = 1'b1;
      r.to   = 1'b1;
      r.cnt  = 32'(TMO - 1);
    end else begin
      r.cnt = 32'(k);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, ecnt, act, exp);
    end
  endtask

  task automatic check_all();
    exp_t x;
    int   s;
    for (int d = 0; d < 3; d++) begin
      s = (d == 0) ? 1 : ((d == 1) ? 2 : 0);
      x = model(s, ecnt);
      chk("done",         d, {31'b0, done_v[d]}, {31'b0, x.done});
      chk("pass",         d, {31'b0, pass_v[d]}, {31'b0, x.pass});
      chk("fail",         d, {31'b0, fail_v[d]}, {31'b0, x.fail});
      chk("timeout",      d, {31'b0, to_v[d]},   {31'b0, x.to});
      chk("fail_testnum", d, tnum_v[d], x.tnum);
      chk("cycle_count",  d, cnt_v[d],  x.cnt);
    end
  endtask

  // One clock edge: log what the DUTs sample, check on the falling edge, idle the bus.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ecnt = 0;
    end else if (ecnt < LOGN - 1) begin
      ecnt++;
      lg_we[ecnt]   = wb_we;
      lg_addr[ecnt] = wb_waddr;
      lg_data[ecnt] = wb_wdata;
    end
    @(negedge clk);
    check_all();
    wb_we    = 1'b0;
    wb_waddr = '0;
    wb_wdata = '0;
  endtask

  task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] dat);
    wb_we    = we;
    wb_waddr = a;
    wb_wdata = dat;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int          e0; logic [4:0] a0; logic [31:0] d0;
    int          e1; logic [4:0] a1; logic [31:0] d1;
    int          e2; logic [4:0] a2; logic [31:0] d2;
    int          len;
    logic        xp; logic xf; logic xt;
    logic [31:0] xtnum;
    logic [31:0] xcnt;
  } row_t;

  row_t tbl [6];

  initial begin
    // Expected columns are for the SETTLE_CYCLES=1 instance.
    tbl[0] = '{10, 5'd27, 32'd1, 20, 5'd26, 32'd1,  0, 5'd0,  32'd0,  30, 1'b1, 1'b0, 1'b0, 32'd0, 32'd22};
    tbl[1] = '{ 5, 5'd3,  32'd7,  8, 5'd27, 32'd0, 12, 5'd26, 32'd1,  20, 1'b0, 1'b1, 1'b0, 32'd7, 32'd14};
    tbl[2] = '{30, 5'd26, 32'd1, 31, 5'd27, 32'd1,  0, 5'd0,  32'd0,  40, 1'b1, 1'b0, 1'b0, 32'd0, 32'd32};
    tbl[3] = '{ 0, 5'd0,  32'd0,  0, 5'd0,  32'd0,  0, 5'd0,  32'd0, 105, 1'b0, 1'b0, 1'b1, 32'd0, 32'd99};
    tbl[4] = '{50, 5'd27, 32'd1, 100, 5'd26, 32'd1, 0, 5'd0,  32'd0, 110, 1'b1, 1'b0, 1'b0, 32'd0, 32'd102};
    tbl[5] = '{10, 5'd27, 32'd1, 20, 5'd26, 32'd2, 30, 5'd0,  32'd1, 105, 1'b0, 1'b0, 1'b1, 32'd0, 32'd99};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 1; k <= tbl[i].len; k++) begin
        if (tbl[i].e0 == k)      drive(1'b1, tbl[i].a0, tbl[i].d0);
        else if (tbl[i].e1 == k) drive(1'b1, tbl[i].a1, tbl[i].d1);
        else if (tbl[i].e2 == k) drive(1'b1, tbl[i].a2, tbl[i].d2);
        tick();
      end
      chk("tbl_pass",    i, {31'b0, pass_v[0]}, {31'b0, tbl[i].xp});
      chk("tbl_fail",    i, {31'b0, fail_v[0]}, {31'b0, tbl[i].xf});
      chk("tbl_timeout", i, {31'b0, to_v[0]},   {31'b0, tbl[i].xt});
      chk("tbl_done",    i, {31'b0, done_v[0]}, 32'd1);
      chk("tbl_tnum",    i, tnum_v[0], tbl[i].xtnum);
      chk("tbl_count",   i, cnt_v[0],  tbl[i].xcnt);
    end

    // Late pass write: settle 2 passes, settle 0 fails.
    chk("late_pass_s2", 1, {31'b0, pass_v[1]}, 32'd0);
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      if (k == 30)      drive(1'b1, 5'd26, 32'd1);
      else if (k == 31) drive(1'b1, 5'd27, 32'd1);
      tick();
    end
    chk("late_pass_s2",  1, {31'b0, pass_v[1]}, 32'd1);
    chk("late_cnt_s2",   1, cnt_v[1], 32'd33);
    chk("late_fail_s0",  2, {31'b0, fail_v[2]}, 32'd1);

    // Writes that must not end the test, then a real end with no pass write.
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      if (k == 1)      drive(1'b1, 5'd26, 32'd2);
      else if (k == 2) drive(1'b1, 5'd0,  32'd1);
      else if (k == 3) drive(1'b0, 5'd26, 32'd1);
      else if (k == 11) drive(1'b1, 5'd26, 32'd1);
      if (k == 10) chk("nonend_done", 0, {29'b0, done_v}, 32'd0);
      tick();
    end
    chk("nonend_then_fail", 0, {31'b0, fail_v[0]}, 32'd1);
    chk("nonend_count",     0, cnt_v[0], 32'd13);

    // Reset while in SETTLE, then a fresh pass run counted from release.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      if (k == 3)      drive(1'b1, 5'd27, 32'd1);
      else if (k == 5) drive(1'b1, 5'd26, 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_done", 0, {29'b0, done_v}, 32'd0);
    chk("midrst_pass", 0, {29'b0, pass_v}, 32'd0);
    chk("midrst_cnt",  0, cnt_v[0], 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2)      drive(1'b1, 5'd27, 32'd1);
      else if (k == 4) drive(1'b1, 5'd26, 32'd1);
      tick();
    end
    chk("midrst_repass", 0, {31'b0, pass_v[0]}, 32'd1);
    chk("midrst_recnt",  0, cnt_v[0], 32'd6);

    // Randomized runs; every edge is compared against the log model.
    for (int run = 0; run < 25; run++) begin
      int   len;
      logic allow_end;
      logic [4:0] a;
      do_reset();
      len = $urandom_range(40, 140);
      allow_end = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 199) == 0) rst = 1'b1;
        if ($urandom_range(0, 99) < 35) begin
          case ($urandom_range(0, 5))
            0:       a = 5'd3;
            1, 2:    a = 5'd27;
            3:       a = allow_end ? 5'd26 : 5'd28;
            4:       a = 5'd0;
            default: a = 5'($urandom_range(0, 31));
          endcase
          case ($urandom_range(0, 3))
            0:       drive($urandom_range(0, 5) != 0, a, 32'd0);
            1, 2:    drive($urandom_range(0, 5) != 0, a, 32'd1);
            default: drive($urandom_range(0, 5) != 0, a, $urandom);
          endcase
        end
        tick();
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_end_monitor.md
Name: sim_end_monitor

Overview:
- Parametrised, cycle-accurate pass/fail/timeout monitor for the riscv core.
- Snoops the register-file write port and detects the test-end signature (END_REG written with 1). After a settle window it judges pass/fail from PASS_REG.
- Captures the failing test number, enforces a cycle timeout and reports total cycles.
- Replaces hard-coded bench wait/timeout logic; instantiated beside the core in benches and optionally in FPGA builds, where it drives the LEDs.

Parameters:
- CPU_WIDTH, 32, data width of the regfile write port.
- END_REG, 26, register index whose write of value 1 marks test end.
- PASS_REG, 27, register index holding 1 on pass.
- TNUM_REG, 3, register index holding the current test number.
- SETTLE_CYCLES, 1, cycles between end detection and verdict; range 0..255.
- TIMEOUT_CYCLES, 50000, cycles after reset before timeout; must be >= 1.
- CNT_WIDTH, 32, width of the cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wb_we  in  1  regfile write enable.
- wb_waddr  in  5  regfile write address.
- wb_wdata  in  CPU_WIDTH  regfile write data.
- done  out  1  verdict reached (pass, fail or timeout); sticky.
- pass  out  1  test passed; sticky.
- fail  out  1  test failed; sticky.
- timeout  out  1  timeout expired before end signature; sticky.
- fail_testnum  out  CPU_WIDTH  TNUM shadow value at verdict; 0 unless fail.
- cycle_count  out  CNT_WIDTH  cycles spent in RUN and SETTLE; frozen at verdict.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - While rst=1 at a clk edge: all outputs 0, shadows 0, state RUN, counters 0.
  - Reset asserted mid-operation (any state) restarts monitoring from RUN on the next edge.
- Shadow registers:
  - pass_sh and tnum_sh load wb_wdata when wb_we=1 and wb_waddr matches PASS_REG or TNUM_REG respectively.
  - Writes with waddr=0 are ignored entirely.
  - Shadows update in RUN and SETTLE and freeze in DONE.
- States: RUN, SETTLE, DONE.
  - RUN:
    - cycle_count increments each cycle and saturates at all-ones.
    - End event: wb_we=1, waddr==END_REG, wdata==1. On the end event, go to SETTLE and load settle_cnt=SETTLE_CYCLES.
    - If SETTLE_CYCLES=0, go directly to verdict evaluation on the following edge, using shadows that include writes from the end cycle.
    - If cycle_count reaches TIMEOUT_CYCLES-1 with no end event: go to DONE with timeout=1, done=1.
    - End event and timeout expiry in the same cycle: the end event wins, so no timeout.
  - SETTLE:
    - settle_cnt decrements and cycle_count keeps incrementing.
    - Shadows keep tracking, so PASS_REG written one cycle after the end event still counts.
    - When settle_cnt reaches 0, evaluate in the same edge: pass_sh==1 gives pass=1; otherwise fail=1 and fail_testnum=tnum_sh. done=1, next state DONE.
    - Timeout is not checked in SETTLE.
    - Re-writing END_REG during SETTLE is ignored.
  - DONE:
    - All outputs hold until rst.
    - Further bus activity has no effect.
- Verdict latency: verdict outputs rise SETTLE_CYCLES+1 edges after the edge sampling the end event.
- Outputs are registered only; no combinational paths from inputs to outputs.
- Exactly one of pass/fail/timeout is ever set per run.
- END_REG writes with wdata != 1 are not end events.

Optional Feature:
- Macro: MONITOR_TRACE_EN.
- Defined:
  - Adds a simulation-only $display on each verdict: "PASS", "FAIL testnum=%d", or "TIMEOUT", plus cycle_count.
  - On fail, also prints all writes captured to TNUM_REG.
  - Tracing is non-synthesizable and enclosed in the macro guard.
- Undefined: no display code; the module is fully synthesizable and functionally identical.

Decomposition:
- Shared defines file holds:
  - CPU_WIDTH default.
  - State encodings: MON_RUN=2'd0, MON_SETTLE=2'd1, MON_DONE=2'd2.
  - Default register indices for the end, pass and test-number registers.
- One natural sub-module: sat_counter (parametrised width, enable, synchronous clear, saturating). It is used for cycle_count; settle_cnt stays inline.
- FSM and shadows live in the top.

Test Plan:
- Pass: write x27=1 at cycle 10, x26=1 at cycle 20, SETTLE_CYCLES=1 -> pass=1, done=1 at cycle 22; cycle_count=22; fail_testnum=0.
- Fail with testnum: write x3=7, x27=0, then x26=1 -> fail=1, fail_testnum=7, pass=0, timeout=0.
- Late pass inside settle: x26=1 at cycle 30, x27=1 at cycle 31, SETTLE_CYCLES=2 -> pass=1 at cycle 33. With SETTLE_CYCLES=0, the same stimulus gives fail=1.
- Timeout: TIMEOUT_CYCLES=100, no end write -> timeout=1, done=1 at cycle 100; cycle_count frozen at 99. With x26=1 coincident at cycle 99 -> no timeout, verdict follows.
- Non-end writes: x26=2, x0=1, and waddr=26 with we=0 -> remain in RUN, no outputs set.
- Reset mid-run: assert rst during SETTLE -> all outputs 0 next edge. A subsequent pass sequence yields pass=1 with cycle_count counted from reset release.
